// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op codes, the FSM state encodings and the divide-by-zero quotient.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Multiply: acc = {partial_high, remaining_multiplier}; conditional add then shift right.
// Divide:   acc = {remainder, dividend/quotient}; restoring shift-subtract,
//           the new quotient bit lands in acc_next[0].
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // compute the next accumulator for the selected operation
  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = acc;
    if (!is_div) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, operand};
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the execute stage.
// Signed ops run on magnitudes; signs are reapplied in FIX.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one CALC cycle
// using a single full-width multiply (latency 2); divides are unchanged.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_CALC | one multiply/divide iteration per clock
// S_FIX  | sign correction, HI/LO update, done pulse follows
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e               state, state_next;
  logic                 div_r;
  logic                 neg_res, neg_rem, div0;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     operand;
  logic                 sgn;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH-1:0]     rem, quo;

  assign sgn   = op_is_signed(op);
  assign a_abs = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs = (sgn && b[WIDTH-1]) ? -b : b;
  assign rem   = acc[2*WIDTH-1:WIDTH];
  assign quo   = acc[WIDTH-1:0];
  assign busy  = (state != S_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_r),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
        if (!div_r || cnt == CNT_LAST) state_next = S_FIX;
`else
        if (cnt == CNT_LAST) state_next = S_FIX;
`endif
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // operand capture, iteration, sign fix and HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      acc     <= '0;
      operand <= '0;
      cnt     <= '0;
      div_r   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_r   <= op_is_div(op);
            cnt     <= '0;
            neg_res <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= sgn & a[WIDTH-1];
            div0    <= op_is_div(op) && (b == '0);
            if (op_is_div(op)) begin
              acc     <= {{WIDTH{1'b0}}, a_abs};
              operand <= b_abs;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_abs};
              operand <= a_abs;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          if (!div_r) acc <= {{WIDTH{1'b0}}, operand} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
          else
`endif
          acc <= acc_step;
        end
        S_FIX: begin
          done <= 1'b1;
          if (div_r) begin
            // a zero divisor leaves the dividend magnitude in rem; its sign fix restores a
            hi <= neg_rem ? -rem : rem;
            lo <= div0 ? WIDTH'(DIV0_QUOT) : (neg_res ? -quo : quo);
          end else begin
            {hi, lo} <= neg_res ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} and completion cycle are
// queued at issue; a monitor compares whenever done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  function automatic int lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 2;
`else
    return 33;
`endif
  endfunction

  // reference results from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
        check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inject, input bit wr_with_start);
    logic [63:0] e;
    int n;
    e = model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (wr_with_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    end
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1 + lat(o));
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    check("busy_after_start", 64'(busy), 64'(1));
    if (wr_with_start) begin
      check("hi_start_wins", 64'(hi), 64'(mhi));
      check("lo_start_wins", 64'(lo), 64'(mlo));
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == inject) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_AAAA; op = 2'b00;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0;
    check("busy_cycles", 64'(n), 64'(lat(o)));
    mhi = e[63:32];
    mlo = e[31:0];
    check("hilo_after_op", {hi, lo}, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int sel;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b11, 32'd7, 32'd2, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, 1'b0);

    // start and mthi while busy are ignored
    run_op(2'b11, 32'd100, 32'd7, 5, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    mlo = 32'h55;
    check("mtlo_lo", 64'(lo), 64'(mlo));
    check("mtlo_hi_unchanged", 64'(hi), 64'(mhi));

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    mhi = 32'h1357_9BDF; mlo = 32'h1357_9BDF;
    check("mthi_mtlo_both", {hi, lo}, {mhi, mlo});

    run_op(2'b01, 32'd12345, 32'd6789, 0, 1'b1);

    // reset in the middle of a MULT
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mhi = '0; mlo = '0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_hilo", {hi, lo}, 64'(0));
    repeat (40) @(negedge clk);
    check("midrst_hilo_hold", {hi, lo}, 64'(0));
    run_op(2'b00, 32'hFFFF_FF85, 32'h0001_0001, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      rx  = (sel == 9) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       ry = 32'h0;
        1:       ry = 32'hFFFF_FFFF;
        2, 3:    ry = 32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      run_op(ro, rx, ry, 0, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
